// File: rtl/timer_entry_pkg.sv
// ============================================================================
//  Module      : timer_entry_pkg
//  Description : Shared definitions for the microwave timer keypad front end:
//                FSM state encoding, special key codes and BCD digit width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_entry_pkg;

    // Width of one BCD digit on the buffer and load bus
    localparam int BCD_W = 4;

    // Non-digit key codes
    localparam logic [3:0] KEY_START = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    // Timer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // True for key codes 0-9
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_entry_if.sv
// ============================================================================
//  Module      : timer_entry_if
//  Description : Keypad / counter-load bus of the timer front end.
//                master : timer_entry (consumes keys and timer_zero, drives
//                         the counter load bus and status)
//                slave  : keypad, counter chain and display side
//  Signals     : key_valid, key_code, timer_zero, load_data, loadn, tmr_en,
//                disp_data, entry_active, running
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_entry_if #(
    parameter int NDIGITS = 4
);
    logic                 key_valid;
    logic [3:0]           key_code;
    logic                 timer_zero;
    logic [4*NDIGITS-1:0] load_data;
    logic                 loadn;
    logic                 tmr_en;
    logic [4*NDIGITS-1:0] disp_data;
    logic                 entry_active;
    logic                 running;

    modport master (
        input  key_valid, key_code, timer_zero,
        output load_data, loadn, tmr_en, disp_data, entry_active, running
    );

    modport slave (
        output key_valid, key_code, timer_zero,
        input  load_data, loadn, tmr_en, disp_data, entry_active, running
    );
endinterface

`default_nettype wire

// File: rtl/timer_entry_shift_reg.sv
// ============================================================================
//  Module      : entry_shift_reg
//  Description : NDIGITS x 4-bit BCD entry buffer. New digits enter at digit 0
//                and push older digits up; the oldest digit falls off the top
//                once the buffer is full. Keeps a saturating digit count.
//  Ports       : clk, clrn (async active-low reset)
//                clr    - empty the buffer (with shift: restart with digit)
//                shift  - shift digit in at position 0
//                digit  - BCD digit to shift in
//                buffer - current buffer contents, digit i at [4i+3:4i]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module entry_shift_reg
    import timer_entry_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     clr,
    input  logic                     shift,
    input  logic [BCD_W-1:0]         digit,
    output logic [BCD_W*NDIGITS-1:0] buffer
);

    localparam int W     = BCD_W * NDIGITS;
    localparam int CNT_W = $clog2(NDIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NDIGITS);

    logic [W-1:0]     buf_q;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            buf_q <= '0;
            count <= '0;
        end else if (shift) begin
            if (clr) begin
                // First digit of a fresh entry
                buf_q <= {{(W-BCD_W){1'b0}}, digit};
                count <= CNT_W'(1);
            end else begin
                buf_q <= {buf_q[W-BCD_W-1:0], digit};
                if (count != CNT_FULL) begin
                    count <= count + 1'b1;
                end
            end
        end else if (clr) begin
            buf_q <= '0;
            count <= '0;
        end
    end

    assign buffer = buf_q;

endmodule

`default_nettype wire

// File: rtl/timer_entry.sv
// ============================================================================
//  Module      : timer_entry
//  Description : Keypad front end of the microwave timer. Collects BCD digits
//                into the entry buffer, sequences IDLE/ENTRY/LOAD/RUN and
//                drives the parallel-load interface of the digit counters.
//  Ports       : clk, clrn (async active-low reset)
//                bus (timer_entry_if.master): key_valid, key_code, timer_zero
//                in; load_data, loadn, tmr_en, disp_data, entry_active,
//                running out
//  Config      : TIMER_ENTRY_SEC_CLAMP_EN - when defined, a seconds value
//                above 59 is loaded as 59 (buffer itself is left untouched)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_entry
    import timer_entry_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic          clk,
    input  logic          clrn,
    timer_entry_if.master bus
);

    localparam int W = BCD_W * NDIGITS;

    state_t       state;
    state_t       next_state;
    logic         first_run;
    logic         buf_clr;
    logic         buf_shift;
    logic [W-1:0] buffer;
    logic [W-1:0] load_value;

    logic         key_digit;
    logic         key_start;
    logic         key_clear;
    logic         buffer_zero;

    // Registered outputs and their next values
    logic [W-1:0] load_data_q;
    logic         loadn_q;
    logic         tmr_en_q;
    logic         entry_q;
    logic         running_q;
    logic [W-1:0] load_data_d;
    logic         loadn_d;
    logic         tmr_en_d;
    logic         entry_d;
    logic         running_d;

    assign key_digit   = bus.key_valid && is_digit(bus.key_code);
    assign key_start   = bus.key_valid && (bus.key_code == KEY_START);
    assign key_clear   = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign buffer_zero = (buffer == '0);

    entry_shift_reg #(
        .NDIGITS (NDIGITS)
    ) u_shift (
        .clk    (clk),
        .clrn   (clrn),
        .clr    (buf_clr),
        .shift  (buf_shift),
        .digit  (bus.key_code),
        .buffer (buffer)
    );

    // Seconds clamp applied only on the way to the counters
`ifdef TIMER_ENTRY_SEC_CLAMP_EN
    always_comb begin
        load_value = buffer;
        if (buffer[2*BCD_W-1:BCD_W] > 4'd5) begin
            load_value[2*BCD_W-1:BCD_W] = 4'd5;
            load_value[BCD_W-1:0]       = 4'd9;
        end
    end
`else
    assign load_value = buffer;
`endif

    // ------------------------------------------------------------------
    // State register (outputs registered alongside so they change with
    // the state they decode)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            first_run   <= 1'b0;
            load_data_q <= '0;
            loadn_q     <= 1'b1;
            tmr_en_q    <= 1'b0;
            entry_q     <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state       <= next_state;
            // Counters only reflect the loaded value one cycle after LOAD,
            // so timer_zero is not trusted during the first RUN cycle.
            first_run   <= (state == ST_LOAD);
            load_data_q <= load_data_d;
            loadn_q     <= loadn_d;
            tmr_en_q    <= tmr_en_d;
            entry_q     <= entry_d;
            running_q   <= running_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and buffer control
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        buf_clr    = 1'b0;
        buf_shift  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_digit) begin
                    next_state = ST_ENTRY;
                    buf_clr    = 1'b1;
                    buf_shift  = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (key_clear) begin
                    next_state = ST_IDLE;
                    buf_clr    = 1'b1;
                end else if (key_start) begin
                    if (!buffer_zero) begin
                        next_state = ST_LOAD;
                    end
                end else if (key_digit) begin
                    buf_shift = 1'b1;
                end
            end
            ST_LOAD: begin
                // Keys in this cycle are dropped
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (key_clear || (bus.timer_zero && !first_run)) begin
                    next_state = ST_IDLE;
                    buf_clr    = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode of the upcoming state
    // ------------------------------------------------------------------
    always_comb begin
        loadn_d     = (next_state != ST_LOAD);
        tmr_en_d    = (next_state == ST_LOAD) || (next_state == ST_RUN);
        entry_d     = (next_state == ST_ENTRY);
        running_d   = (next_state == ST_RUN);
        load_data_d = load_data_q;
        if (next_state == ST_LOAD) begin
            load_data_d = load_value;
        end
    end

    assign bus.load_data    = load_data_q;
    assign bus.loadn        = loadn_q;
    assign bus.tmr_en       = tmr_en_q;
    assign bus.entry_active = entry_q;
    assign bus.running      = running_q;
    assign bus.disp_data    = buffer;

endmodule

`default_nettype wire
